// File: rtl/rgb_capture_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : rgb_capture_pkg                                         |
// | Description : Shared constants for the RGB565 capture block: state    |
// |               encoding, video pin polarities and pixel field layout.  |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
package rgb_capture_pkg;

    // Pixel bus width and the synchronized bus {pclk, hsync, vsync, de, color}
    localparam int PIX_W  = 16;
    localparam int SYNC_W = PIX_W + 4;

    // Capture state encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SEEK  = 2'd1;
    localparam logic [1:0] c_FRAME = 2'd2;

    // Pin polarities: syncs are active-low, data enable is active-high
    localparam logic c_SYNC_ACTIVE = 1'b0;
    localparam logic c_SYNC_IDLE   = 1'b1;
    localparam logic c_DE_ACTIVE   = 1'b1;

    // RGB565 field offsets within a pixel word
    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/rgb_capture_sync.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : rgb_capture_sync                                        |
// | Description : Two-flop synchronizer bank for the 20 video pins, the   |
// |               pclk falling-edge sample detector and the registers     |
// |               holding vsync/de as seen at the previous sample.        |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module rgb_capture_sync
    import rgb_capture_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_pclk,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_de,
    input  logic [PIX_W-1:0] i_color,
    output logic             o_sample,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic [PIX_W-1:0] o_color,
    output logic             o_vsync_prev,
    output logic             o_de_prev
);

    // pclk resets low so that leaving reset can never fake a falling edge
    localparam logic [SYNC_W-1:0] c_SYNC_RST =
        {1'b0, c_SYNC_IDLE, c_SYNC_IDLE, ~c_DE_ACTIVE, {PIX_W{1'b0}}};

    logic [SYNC_W-1:0] w_pins;
    logic [SYNC_W-1:0] r_meta;
    logic [SYNC_W-1:0] r_sync;
    logic              r_pclk_d;
    logic              r_vsync_prev;
    logic              r_de_prev;

    assign w_pins = {i_pclk, i_hsync, i_vsync, i_de, i_color};

    // Two-stage synchronizer for every video pin
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= c_SYNC_RST;
            r_sync <= c_SYNC_RST;
        end else begin
            r_meta <= w_pins;
            r_sync <= r_meta;
        end
    end

    // Delayed synchronized pclk for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pclk_d <= 1'b0;
        end else begin
            r_pclk_d <= r_sync[SYNC_W-1];
        end
    end

    // Falling pclk lands mid-eye, since the transmitter launches on the rise
    assign o_sample = r_pclk_d & ~r_sync[SYNC_W-1];

    // vsync/de captured at each sample, giving the reference for edge tests
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsync_prev <= c_SYNC_IDLE;
            r_de_prev    <= ~c_DE_ACTIVE;
        end else if (o_sample) begin
            r_vsync_prev <= r_sync[SYNC_W-3];
            r_de_prev    <= r_sync[SYNC_W-4];
        end
    end

    assign o_hsync      = r_sync[SYNC_W-2];
    assign o_vsync      = r_sync[SYNC_W-3];
    assign o_de         = r_sync[SYNC_W-4];
    assign o_color      = r_sync[PIX_W-1:0];
    assign o_vsync_prev = r_vsync_prev;
    assign o_de_prev    = r_de_prev;

endmodule
`default_nettype wire

// File: rtl/rgb_capture.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : rgb_capture                                             |
// | Description : Oversampling RGB565 video capture. Recovers pixel       |
// |               coordinates, emits one write strobe per active pixel,   |
// |               checks frame geometry and reports lock and errors.      |
// |               Macro RGB_CAPTURE_MEASURE_EN builds the meas_width /    |
// |               meas_height registers and the two-frame lock qualifier. |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module rgb_capture
    import rgb_capture_pkg::*;
#(
    parameter int WIDTH  = 480,
    parameter int HEIGHT = 480,
    parameter int XW     = 10,
    parameter int YW     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pclk_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             de_in,
    input  logic [PIX_W-1:0] color_in,
    output logic             pix_valid,
    output logic [XW-1:0]    pix_x,
    output logic [YW-1:0]    pix_y,
    output logic [PIX_W-1:0] pix_color,
    output logic             frame_start,
    output logic             frame_done,
    output logic             locked,
    output logic             err_overrun,
    output logic             err_short,
    output logic [XW-1:0]    meas_width,
    output logic [YW-1:0]    meas_height
);

    localparam logic [XW-1:0] c_WIDTH  = XW'(WIDTH);
    localparam logic [YW-1:0] c_HEIGHT = YW'(HEIGHT);
    localparam logic [XW-1:0] c_X_MAX  = {XW{1'b1}};
    localparam logic [YW-1:0] c_Y_MAX  = {YW{1'b1}};

    logic             w_sample;
    logic             w_hsync_s;
    logic             w_vsync_s;
    logic             w_de_s;
    logic [PIX_W-1:0] w_color_s;
    logic             w_vsync_prev;
    logic             w_de_prev;

    rgb_capture_sync u_sync (
        .clk          (clk),
        .reset        (reset),
        .i_pclk       (pclk_in),
        .i_hsync      (hsync_in),
        .i_vsync      (vsync_in),
        .i_de         (de_in),
        .i_color      (color_in),
        .o_sample     (w_sample),
        .o_hsync      (w_hsync_s),
        .o_vsync      (w_vsync_s),
        .o_de         (w_de_s),
        .o_color      (w_color_s),
        .o_vsync_prev (w_vsync_prev),
        .o_de_prev    (w_de_prev)
    );

    logic [1:0]    r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_start_pend;

    logic          w_vsync_fall;
    logic          w_de_fall;
    logic          w_de_beat;
    logic          w_in_frame;
    logic          w_frame_open;
    logic          w_in_range;
    logic          w_px_ok;
    logic          w_px_ovr;
    logic          w_line_end;
    logic          w_frame_close;
    logic [XW-1:0] w_x_inc;
    logic [YW-1:0] w_y_inc;
    logic [YW-1:0] w_y_lined;
    logic          w_err_short_n;
    logic          w_err_any;

    assign w_vsync_fall  = w_sample & (w_vsync_prev == c_SYNC_IDLE) & (w_vsync_s == c_SYNC_ACTIVE);
    assign w_de_fall     = w_sample & (w_de_prev == c_DE_ACTIVE) & (w_de_s != c_DE_ACTIVE);
    assign w_de_beat     = w_sample & (w_de_s == c_DE_ACTIVE);
    assign w_in_frame    = enable & (r_state == c_FRAME);
    assign w_frame_open  = enable & (r_state == c_SEEK) & w_vsync_fall;
    assign w_in_range    = (r_x < c_WIDTH) & (r_y < c_HEIGHT);
    assign w_px_ok       = w_in_frame & w_de_beat & w_in_range;
    assign w_px_ovr      = w_in_frame & w_de_beat & ~w_in_range;
    assign w_line_end    = w_in_frame & w_de_fall;
    assign w_frame_close = w_in_frame & w_vsync_fall;
    assign w_x_inc       = (r_x == c_X_MAX) ? r_x : r_x + XW'(1);
    assign w_y_inc       = (r_y == c_Y_MAX) ? r_y : r_y + YW'(1);
    // Line end is applied before frame close, so a coincident line counts
    assign w_y_lined     = w_line_end ? w_y_inc : r_y;
    assign w_err_short_n = (w_line_end & (r_x < c_WIDTH)) |
                           (w_frame_close & (w_y_lined < c_HEIGHT));
    assign w_err_any     = w_px_ovr | w_err_short_n;

    // Capture state machine and x/y position counters
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_state <= c_IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                c_IDLE: r_state <= c_SEEK;
                c_SEEK: begin
                    if (w_vsync_fall) begin
                        r_state <= c_FRAME;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                c_FRAME: begin
                    if (w_vsync_fall) begin
                        r_x <= '0;
                        r_y <= '0;
                    end else if (w_de_fall) begin
                        r_x <= '0;
                        r_y <= w_y_inc;
                    end else if (w_de_beat) begin
                        r_x <= w_x_inc;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Pixel write port; coordinates and data hold between strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= '0;
        end else begin
            pix_valid <= w_px_ok;
            if (w_px_ok) begin
                pix_x     <= r_x;
                pix_y     <= r_y;
                pix_color <= w_color_s;
            end
        end
    end

    // Frame and error pulses; a restart's frame_start trails frame_done by one
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
            err_overrun  <= 1'b0;
            err_short    <= 1'b0;
            r_start_pend <= 1'b0;
        end else begin
            frame_start  <= w_frame_open | (enable & r_start_pend);
            frame_done   <= w_frame_close;
            err_overrun  <= w_px_ovr;
            err_short    <= w_err_short_n;
            r_start_pend <= w_frame_close;
        end
    end

`ifdef RGB_CAPTURE_MEASURE_EN
    logic [XW-1:0] r_meas_width;
    logic [YW-1:0] r_meas_height;
    logic          r_good_once;
    logic          r_frame_err;
    logic          r_locked;
    logic [XW-1:0] w_width_n;
    logic          w_frame_good;

    assign w_width_n    = w_line_end ? r_x : r_meas_width;
    assign w_frame_good = w_frame_close & ~(r_frame_err | w_err_any) &
                          (w_width_n == c_WIDTH) & (w_y_lined == c_HEIGHT);

    // Geometry measurement and two-consecutive-good-frames lock
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meas_width  <= '0;
            r_meas_height <= '0;
            r_good_once   <= 1'b0;
            r_frame_err   <= 1'b0;
            r_locked      <= 1'b0;
        end else if (!enable) begin
            r_good_once <= 1'b0;
            r_frame_err <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            if (w_line_end) begin
                r_meas_width <= r_x;
            end
            if (w_frame_close) begin
                r_meas_height <= w_y_lined;
            end
            if (w_err_any) begin
                r_locked <= 1'b0;
            end
            if (w_frame_close || w_frame_open) begin
                r_frame_err <= 1'b0;
            end else if (w_err_any) begin
                r_frame_err <= 1'b1;
            end
            if (w_frame_close) begin
                r_good_once <= w_frame_good;
                if (w_frame_good && r_good_once) begin
                    r_locked <= 1'b1;
                end
            end else if (w_err_any) begin
                r_good_once <= 1'b0;
            end
        end
    end

    assign meas_width  = r_meas_width;
    assign meas_height = r_meas_height;
    assign locked      = r_locked;
`else
    logic r_frame_err;
    logic r_locked;

    // Lock after any single frame that closes without an error pulse
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_frame_err <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            if (w_frame_close || w_frame_open) begin
                r_frame_err <= 1'b0;
            end else if (w_err_any) begin
                r_frame_err <= 1'b1;
            end
            if (w_err_any) begin
                r_locked <= 1'b0;
            end else if (w_frame_close && !r_frame_err) begin
                r_locked <= 1'b1;
            end
        end
    end

    assign meas_width  = '0;
    assign meas_height = '0;
    assign locked      = r_locked;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rgb_capture.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_rgb_capture                                          |
// | Description : Scoreboard bench for rgb_capture at 8x4 geometry with   |
// |               generator-style video at clk = 4x pclk.                 |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_rgb_capture;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int XW = 10;
    localparam int YW = 10;
`ifdef RGB_CAPTURE_MEASURE_EN
    localparam bit MEAS = 1'b1;
`else
    localparam bit MEAS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          pclk_in = 1'b0;
    logic          hsync_in = 1'b1;
    logic          vsync_in = 1'b1;
    logic          de_in = 1'b0;
    logic [15:0]   color_in = '0;
    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [15:0]   pix_color;
    logic          frame_start;
    logic          frame_done;
    logic          locked;
    logic          err_overrun;
    logic          err_short;
    logic [XW-1:0] meas_width;
    logic [YW-1:0] meas_height;

    rgb_capture #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pclk_in(pclk_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .de_in(de_in), .color_in(color_in),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .frame_start(frame_start), .frame_done(frame_done), .locked(locked),
        .err_overrun(err_overrun), .err_short(err_short),
        .meas_width(meas_width), .meas_height(meas_height)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [15:0]   c;
    } pix_t;

    pix_t exp_q[$];
    int got_done = 0, got_start = 0, got_ovr = 0, got_short = 0;
    int exp_done = 0, exp_start = 0, exp_ovr = 0, exp_short = 0;

    // Reference model: 0 idle, 1 waiting for vsync, 2 inside a frame
    int m_mode = 0;
    int m_x = 0, m_y = 0, m_mw = 0, m_mh = 0, m_good = 0;
    bit m_locked = 0, m_ferr = 0;
    bit m_pvs = 1'b1, m_pde = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // One pclk falling edge as the spec describes it, in whole-pixel terms
    function automatic void model_sample(input bit vs, input bit de, input logic [15:0] col);
        bit vf, df, sh, err;
        pix_t p;
        vf = m_pvs && !vs;
        df = m_pde && !de;
        m_pvs = vs;
        m_pde = de;
        if (m_mode == 1 && vf) begin
            m_mode = 2; m_x = 0; m_y = 0; m_ferr = 0;
            exp_start++;
        end else if (m_mode == 2) begin
            sh = 0; err = 0;
            if (de) begin
                if (m_x < W && m_y < H) begin
                    p.x = XW'(m_x); p.y = YW'(m_y); p.c = col;
                    exp_q.push_back(p);
                end else begin
                    exp_ovr++; err = 1;
                end
                m_x++;
            end
            if (df) begin
                m_mw = m_x;
                if (m_x < W) sh = 1;
                m_y++; m_x = 0;
            end
            if (vf) begin
                m_mh = m_y;
                if (m_y < H) sh = 1;
            end
            if (sh) begin exp_short++; err = 1; end
            if (err) begin m_ferr = 1; m_locked = 0; m_good = 0; end
            if (vf) begin
                exp_done++; exp_start++;
                if (!m_ferr && (!MEAS || (m_mw == W && m_mh == H))) begin
                    m_good++;
                    if (m_good >= (MEAS ? 2 : 1)) m_locked = 1;
                end else begin
                    m_good = 0;
                end
                m_ferr = 0; m_x = 0; m_y = 0;
            end
        end
    endfunction

    // Monitor: counts pulses and pops expected pixels on every strobe
    always @(negedge clk) begin
        pix_t e;
        if (frame_done)  got_done++;
        if (frame_start) got_start++;
        if (err_overrun) got_ovr++;
        if (err_short)   got_short++;
        if (pix_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pix_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pix_x", pix_x, e.x);
                check("pix_y", pix_y, e.y);
                check("pix_color", pix_color, e.c);
            end
        end
    end

    // One pclk period: launch on the rise, 2 clk high, 2 clk low
    task automatic pcyc(input bit vs, input bit hs, input bit de, input logic [15:0] col);
        @(negedge clk);
        pclk_in = 1'b1; vsync_in = vs; hsync_in = hs; de_in = de; color_in = col;
        @(negedge clk);
        @(negedge clk);
        pclk_in = 1'b0;
        model_sample(vs, de, col);
        @(negedge clk);
    endtask

    task automatic send_pixels(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) pcyc(1'b1, 1'b1, 1'b1, {8'(y), 8'(x)});
    endtask

    task automatic line_end();
        pcyc(1'b1, 1'b0, 1'b0, 16'h0);
        pcyc(1'b1, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic send_line(input int y, input int len);
        send_pixels(y, 0, len - 1);
        line_end();
    endtask

    task automatic vsync_pulse();
        pcyc(1'b0, 1'b1, 1'b0, 16'h0);
        pcyc(1'b1, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic full_body();
        for (int l = 0; l < H; l++) send_line(l, W);
    endtask

    task automatic set_enable(input bit en);
        repeat (4) @(negedge clk);
        enable = en;
        if (!en) begin
            m_mode = 0; m_x = 0; m_y = 0; m_locked = 0; m_good = 0; m_ferr = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end
    endtask

    task automatic checkpoint(input string tag);
        repeat (8) @(negedge clk);
        check({tag, "_frame_done_count"}, got_done, exp_done);
        check({tag, "_frame_start_count"}, got_start, exp_start);
        check({tag, "_overrun_count"}, got_ovr, exp_ovr);
        check({tag, "_short_count"}, got_short, exp_short);
        check({tag, "_missing_pixels"}, exp_q.size(), 0);
        check({tag, "_locked"}, locked, m_locked);
        check({tag, "_meas_width"}, meas_width, MEAS ? m_mw : 0);
        check({tag, "_meas_height"}, meas_height, MEAS ? m_mh : 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_pix_x"}, pix_x, 0);
        check({tag, "_pix_y"}, pix_y, 0);
        check({tag, "_pix_color"}, pix_color, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_err_overrun"}, err_overrun, 0);
        check({tag, "_err_short"}, err_short, 0);
        check({tag, "_meas_width"}, meas_width, 0);
        check({tag, "_meas_height"}, meas_height, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        set_enable(1'b1);

        // Nominal frames with random idle time between them
        vsync_pulse();
        full_body();
        vsync_pulse();
        full_body();
        vsync_pulse();
        checkpoint("nominal2");
        full_body();
        repeat ($urandom_range(0, 20)) @(negedge clk);
        vsync_pulse();
        checkpoint("nominal3");

        // Overlong third line
        for (int l = 0; l < 3; l++) send_line(l, (l == 2) ? 10 : W);
        checkpoint("overlong_line");
        send_line(3, W);
        vsync_pulse();
        checkpoint("overlong_frame");

        // Short frame, then one clean frame
        for (int l = 0; l < 3; l++) send_line(l, W);
        vsync_pulse();
        checkpoint("short_frame");
        full_body();
        vsync_pulse();
        checkpoint("after_short");

        // Enable dropped after 5 pixels; re-enabled mid-frame
        send_pixels(0, 0, 4);
        set_enable(1'b0);
        checkpoint("enable_off");
        send_pixels(0, 5, W - 1);
        line_end();
        send_line(1, W);
        set_enable(1'b1);
        send_line(2, W);
        send_line(3, W);
        vsync_pulse();
        full_body();
        vsync_pulse();
        checkpoint("reenable");

        // pclk stopped for 1000 clk mid-line with a random resume point
        begin
            int stop_x;
            stop_x = $urandom_range(1, W - 2);
            send_line(0, W);
            send_line(1, W);
            send_pixels(2, 0, stop_x - 1);
            repeat (1000) @(negedge clk);
            send_pixels(2, stop_x, W - 1);
            line_end();
            send_line(3, W);
            vsync_pulse();
            checkpoint("stalled_pclk");
        end

        // Reset at x=4 mid-line
        send_pixels(0, 0, 3);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check_zero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        m_mode = 1; m_x = 0; m_y = 0; m_locked = 0; m_good = 0; m_ferr = 0;
        m_pvs = 1'b1; m_pde = 1'b0; m_mw = 0; m_mh = 0;
        send_pixels(0, 4, W - 1);
        line_end();
        for (int l = 1; l < H; l++) send_line(l, W);
        checkpoint("after_reset_line");
        vsync_pulse();
        full_body();
        vsync_pulse();
        checkpoint("post_reset_frame");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
